// File: rtl/ring_seq_pkg.sv
// Shared definitions for the ring group/phase sequencer.
// Optional feature macro used by this slice: RGS_DIRECT_SEL_EN.
package ring_seq_pkg;

  // Phase step direction encodings (value of the dir input)
  localparam logic RGS_DIR_UP = 1'b0;
  localparam logic RGS_DIR_DN = 1'b1;

  // Field width for an index in 0..n-1, never narrower than one bit
  function automatic int clog2_min1(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/ring_seq_mod_cnt.sv
// Modulo-N up/down counter with enable, synchronous load and a wrap flag.
// wrap reports that the next enabled step would wrap (N-1 -> 0 up, 0 -> N-1 down);
// the instantiating logic decides whether that step is actually taken.
import ring_seq_pkg::*;

module ring_seq_mod_cnt #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dn,
  output logic [W-1:0] val,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V  = W'(N - 1);
  localparam logic [W-1:0] ZERO_V = {W{1'b0}};
  localparam logic [W-1:0] ONE_V  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] val_r;
  logic         wrap_s;

  // Wrap detection by explicit compare so non-power-of-2 N never leaves 0..N-1
  always_comb begin
    wrap_s = 1'b0;
    if (dn == RGS_DIR_DN) begin
      wrap_s = (val_r == ZERO_V);
    end else begin
      wrap_s = (val_r == MAX_V);
    end
  end

  // Counter register: load wins over step, otherwise hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_r <= ZERO_V;
    end else if (load) begin
      val_r <= load_val;
    end else if (en) begin
      if (dn == RGS_DIR_DN) begin
        val_r <= wrap_s ? MAX_V : (val_r - ONE_V);
      end else begin
        val_r <= wrap_s ? ZERO_V : (val_r + ONE_V);
      end
    end else begin
      val_r <= val_r;
    end
  end

  assign val  = val_r;
  assign wrap = wrap_s;

endmodule

// File: rtl/ring_group_sequencer.sv
// Group/phase sequencer: sw=0 steps the phase inside the current group,
// sw=1 hops to the next group keeping the phase. Outputs are registered.
// Optional macro RGS_DIRECT_SEL_EN adds sel_vld/sel_grp for a direct group jump.
import ring_seq_pkg::*;

module ring_group_sequencer #(
  parameter  int NUM_GROUPS = 2,
  parameter  int GROUP_LEN  = 2,
  localparam int GW         = clog2_min1(NUM_GROUPS),
  localparam int PW         = clog2_min1(GROUP_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sw,
  input  logic              dir,
`ifdef RGS_DIRECT_SEL_EN
  input  logic              sel_vld,
  input  logic [GW-1:0]     sel_grp,
`endif
  output logic [GW-1:0]     grp_o,
  output logic [PW-1:0]     phase_o,
  output logic [GW+PW-1:0]  state_o,
  output logic              switch_o,
  output logic              wrap_o
);

  typedef struct packed {
    logic [GW-1:0] grp;
    logic [PW-1:0] phase;
  } rgs_state_t;

  // One extra bit so the group/phase counts themselves are representable
  localparam logic [GW:0] NG_L = (GW+1)'(NUM_GROUPS);
  localparam logic [PW:0] GL_L = (PW+1)'(GROUP_LEN);

  rgs_state_t    cur_s;
  logic          illegal_s;
  logic          ph_en_s;
  logic          ph_load_s;
  logic          ph_wrap_s;
  logic          gr_en_s;
  logic          gr_load_s;
  logic [GW-1:0] gr_ld_val_s;
  logic          gr_wrap_s;
  logic          switch_s;
  logic          wrap_s;
  logic          switch_r;
  logic          wrap_r;

  assign illegal_s = ({1'b0, cur_s.grp} >= NG_L) || ({1'b0, cur_s.phase} >= GL_L);

  // Step decode: recovery from unreachable codes, then direct select, then sw/dir step
  always_comb begin
    ph_en_s     = 1'b0;
    ph_load_s   = 1'b0;
    gr_en_s     = 1'b0;
    gr_load_s   = 1'b0;
    gr_ld_val_s = {GW{1'b0}};
    switch_s    = 1'b0;
    wrap_s      = 1'b0;
    if (en) begin
      if (illegal_s) begin
        ph_load_s = 1'b1;
        gr_load_s = 1'b1;
`ifdef RGS_DIRECT_SEL_EN
      end else if (sel_vld && ({1'b0, sel_grp} < NG_L)) begin
        gr_load_s   = 1'b1;
        gr_ld_val_s = sel_grp;
        ph_load_s   = 1'b1;
        switch_s    = 1'b1;
`endif
      end else if (sw) begin
        gr_en_s  = 1'b1;
        switch_s = 1'b1;
      end else begin
        ph_en_s = 1'b1;
        wrap_s  = ph_wrap_s;
      end
    end else begin
      ph_en_s = 1'b0;
      gr_en_s = 1'b0;
    end
  end

  ring_seq_mod_cnt #(
    .N (GROUP_LEN),
    .W (PW)
  ) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (ph_en_s),
    .load     (ph_load_s),
    .load_val ({PW{1'b0}}),
    .dn       (dir),
    .val      (cur_s.phase),
    .wrap     (ph_wrap_s)
  );

  ring_seq_mod_cnt #(
    .N (NUM_GROUPS),
    .W (GW)
  ) u_group_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (gr_en_s),
    .load     (gr_load_s),
    .load_val (gr_ld_val_s),
    .dn       (RGS_DIR_UP),
    .val      (cur_s.grp),
    .wrap     (gr_wrap_s)
  );

  // Single-cycle event pulses, cleared whenever no step is taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      switch_r <= 1'b0;
      wrap_r   <= 1'b0;
    end else begin
      switch_r <= switch_s;
      wrap_r   <= wrap_s;
    end
  end

  assign grp_o    = cur_s.grp;
  assign phase_o  = cur_s.phase;
  assign state_o  = cur_s;
  assign switch_o = switch_r;
  assign wrap_o   = wrap_r;

endmodule
